// File: rtl/mem_stage.sv
// Memory-access stage: issues one load or store on the data-memory bus with a
// ready/wait handshake and bounded wait, then hands the instruction and MDR to write-back.
module mem_stage #(
    parameter int          DATA_W   = 8,
    parameter int          ADDR_W   = 8,
    parameter logic [3:0]  OP_LOAD  = 4'b1001,
    parameter logic [3:0]  OP_STORE = 4'b1010,
    parameter int          TIMEOUT  = 15
) (
    input  logic              t2,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       ir,
    input  logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       wb_ir,
    output logic [DATA_W-1:0] mdr,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [15:0]       wb_ir_q, wb_ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_ir_d     = wb_ir_q;
        mdr_d       = mdr_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wb_ir_d     = ir;
                    mem_addr_d  = ir[ADDR_W-1:0];
                    mem_wdata_d = acc;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    if (ir[15:12] == OP_LOAD)
                        state_d = READ;
                    else if (ir[15:12] == OP_STORE)
                        state_d = WRITE;
                    else
                        state_d = DONE;
                end
            end
            // Loads and stores share the ready/timeout handling; only loads capture data.
            READ, WRITE: begin
                if (mem_ready) begin
                    if (state_q == READ)
                        mdr_d = mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge t2) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_ir_q     <= '0;
            mdr_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_ir_q     <= wb_ir_d;
            mdr_q       <= mdr_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Handshake strobes are pure state decodes, so they drop on the reset edge.
    assign mem_rd    = (state_q == READ);
    assign mem_wr    = (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_ir     = wb_ir_q;
    assign mdr       = mdr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_stage;

    localparam int TIMEOUT = 15;

    logic        t2 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ir = '0;
    logic [7:0]  acc = '0;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata = '0, mdr;
    logic        mem_rd, mem_wr, mem_ready = 1'b0;
    logic [15:0] wb_ir;
    logic        done, busy, err;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    bit check_en = 1'b0;

    mem_stage dut (
        .t2(t2), .rst(rst), .start(start), .ir(ir), .acc(acc),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .wb_ir(wb_ir), .mdr(mdr),
        .done(done), .busy(busy), .err(err)
    );

    always #5 t2 = ~t2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one pending access described by kind and cycles waited so far.
    typedef enum {K_NONE, K_LOAD, K_STORE, K_FINISH} kind_t;
    kind_t       m_kind = K_NONE;
    int          m_waited = 0;
    logic [15:0] m_ir = '0;
    logic [7:0]  m_addr = '0, m_wdata = '0, m_mdr = '0;
    logic        m_err = 1'b0;

    always @(posedge t2) begin
        if (rst) begin
            m_kind = K_NONE; m_waited = 0; m_ir = '0;
            m_addr = '0; m_wdata = '0; m_mdr = '0; m_err = 1'b0;
        end else if (m_kind == K_FINISH) begin
            m_kind = K_NONE;
        end else if (m_kind == K_LOAD || m_kind == K_STORE) begin
            if (mem_ready) begin
                if (m_kind == K_LOAD) m_mdr = mem_rdata;
                m_kind = K_FINISH;
            end else if (m_waited + 1 >= TIMEOUT) begin
                m_err = 1'b1;
                m_kind = K_FINISH;
            end else begin
                m_waited++;
            end
        end else if (start) begin
            m_ir = ir; m_addr = ir[7:0]; m_wdata = acc; m_err = 1'b0; m_waited = 0;
            if (ir[15:12] == 4'h9)      m_kind = K_LOAD;
            else if (ir[15:12] == 4'hA) m_kind = K_STORE;
            else                        m_kind = K_FINISH;
        end
    end

    always @(negedge t2) begin
        if (check_en) begin
            check("mem_rd", mem_rd, m_kind == K_LOAD);
            check("mem_wr", mem_wr, m_kind == K_STORE);
            check("done", done, m_kind == K_FINISH);
            check("busy", busy, m_kind != K_NONE);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("wb_ir", wb_ir, m_ir);
            check("mdr", mdr, m_mdr);
            check("err", err, m_err);
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic applyStimulus(input logic [15:0] i_ir, input logic [7:0] i_acc);
        start = 1'b1; ir = i_ir; acc = i_acc;
        @(negedge t2);
        start = 1'b0;
    endtask

    initial begin
        int rd_cnt;
        int pulses;
        rst = 1'b1;
        repeat (2) @(negedge t2);
        check_en = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_mdr", mdr, 0);
        rst = 1'b0;
        @(negedge t2);

        // Non-memory instruction completes in one cycle.
        applyStimulus(16'h3000, 8'h00);
        check("nonmem_done", done, 1);
        check("nonmem_wb_ir", wb_ir, 16'h3000);
        check("nonmem_mdr", mdr, 8'h00);
        @(negedge t2);
        check("nonmem_idle", busy, 0);

        // Load with immediate ready.
        mem_ready = 1'b1; mem_rdata = 8'hA5;
        applyStimulus(16'h9042, 8'h00);
        check("ld_rd", mem_rd, 1);
        check("ld_addr", mem_addr, 8'h42);
        check("ld_early_done", done, 0);
        @(negedge t2);
        check("ld_done", done, 1);
        check("ld_mdr", mdr, 8'hA5);
        check("ld_err", err, 0);
        mem_ready = 1'b0;
        @(negedge t2);

        // Store with three wait cycles.
        applyStimulus(16'hA010, 8'h5C);
        for (int i = 0; i < 4; i++) begin
            check("st_wr", mem_wr, 1);
            check("st_addr", mem_addr, 8'h10);
            check("st_wdata", mem_wdata, 8'h5C);
            if (i == 3) mem_ready = 1'b1;
            @(negedge t2);
        end
        mem_ready = 1'b0;
        check("st_done", done, 1);
        check("st_mdr", mdr, 8'hA5);
        @(negedge t2);

        // Load that times out.
        rd_cnt = 0;
        applyStimulus(16'h9077, 8'h00);
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            if (mem_rd === 1'b1) rd_cnt++;
            @(negedge t2);
        end
        check("to_wait_done", done, 1);
        check("to_rd_cycles", rd_cnt, 15);
        check("to_err", err, 1);
        check("to_mdr", mdr, 8'hA5);
        @(negedge t2);
        check("to_err_held", err, 1);
        applyStimulus(16'h1234, 8'h00);
        check("to_err_cleared", err, 0);
        check("to_next_done", done, 1);
        @(negedge t2);

        // Start pulses during READ and DONE are ignored.
        pulses = done_seen;
        mem_rdata = 8'h3C;
        applyStimulus(16'h9011, 8'h66);
        applyStimulus(16'h0FFF, 8'hFF);
        mem_ready = 1'b1;
        @(negedge t2);
        mem_ready = 1'b0;
        check("ign_done", done, 1);
        applyStimulus(16'h2222, 8'h11);
        check("ign_idle", busy, 0);
        check("ign_wb_ir", wb_ir, 16'h9011);
        check("ign_wdata", mem_wdata, 8'h66);
        check("ign_mdr", mdr, 8'h3C);
        repeat (2) @(negedge t2);
        check("ign_one_pulse", done_seen - pulses, 1);

        // Reset during a store wait.
        pulses = done_seen;
        applyStimulus(16'hA020, 8'h77);
        @(negedge t2);
        check("rst_in_write", mem_wr, 1);
        rst = 1'b1;
        @(negedge t2);
        rst = 1'b0;
        check("rst_wr", mem_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_wb_ir", wb_ir, 16'h0000);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_mdr", mdr, 8'h00);
        @(negedge t2);
        check("rst_no_done", done_seen - pulses, 0);
        applyStimulus(16'h5555, 8'h00);
        check("post_rst_done", done, 1);
        check("post_rst_wb_ir", wb_ir, 16'h5555);
        repeat (2) @(negedge t2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
